// File: rtl/kappa_pkg.sv
// kappa_pkg: constants shared by the instruction sequencer and the
// datapath controller. It holds the one-hot phase codes driven on cstate,
// the RV32 major opcodes the sequencer recognises, the sticky error codes,
// the sequencer state type, and the helper functions that classify an opcode.
package kappa_pkg;

  // One-hot phase codes presented on cstate.
  localparam logic [3:0] PH_NONE = 4'b0000;
  localparam logic [3:0] PH_IF   = 4'b0001;
  localparam logic [3:0] PH_DE   = 4'b0010;
  localparam logic [3:0] PH_EX   = 4'b0100;
  localparam logic [3:0] PH_WB   = 4'b1000;

  // Major opcodes, taken from ir[6:0].
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Sticky error codes.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_DE, S_EX, S_WB, S_HALT
  } seq_state_t;

  // What the write-back phase has to do for the instruction in flight.
  typedef enum logic [1:0] {
    WB_NONE, WB_LOAD, WB_STORE
  } wb_kind_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM: opcode_legal = 1'b1;
      default:                                      opcode_legal = 1'b0;
    endcase
  endfunction

  function automatic wb_kind_t wb_kind_of(input logic [6:0] op);
    case (op)
      OP_LOAD:  wb_kind_of = WB_LOAD;
      OP_STORE: wb_kind_of = WB_STORE;
      default:  wb_kind_of = WB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts the wait cycles of one memory access and flags
// the cycle on which the access has to be abandoned.
//   clk, rst_n  clock, asynchronous active-low reset
//   active      a memory request is outstanding this cycle
//   mem_ready   memory completes the access this cycle
//   expired     this is request cycle number TIMEOUT and memory is still not ready
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);

  localparam int W = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // The count rests at zero whenever no access is outstanding and returns to
  // zero on completion, so every new access starts from a cleared counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || mem_ready) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + W'(1);
    end
  end

  // Completion wins over timeout when both fall in the same cycle.
  assign expired = active && !mem_ready && (count == LAST);

endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle instruction sequencer (IF -> DE -> EX -> WB).
//   clk, rst_n  clock, asynchronous active-low reset
//   run         level, permits continuous execution
//   step        level, sampled in IDLE, executes exactly one instruction
//   ir          current instruction register
//   mem_ready   memory completes the current access this cycle
//   cstate      one-hot phase (IF/DE/EX/WB), zero in IDLE and HALT
//   adv         current phase completes this cycle
//   mem_req     memory access request; mem_we marks it as a write
//   busy        high outside IDLE and HALT; halted high in HALT
//   err         sticky error code; instret retired-instruction count
module seq_controller
  import kappa_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [3:0]       cstate,
  output logic             adv,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instret
);

  seq_state_t state;
  wb_kind_t   wb_kind;
  logic       single_step;
  logic       expired;

  logic [6:0] opcode;
  logic       unused_ir_bits;
  assign opcode         = ir[6:0];
  assign unused_ir_bits = ^ir[31:7];

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (mem_req),
    .mem_ready (mem_ready),
    .expired   (expired)
  );

  // adv has to rise in the very cycle memory answers, so it is decoded from
  // the registered state and the live mem_ready instead of being registered.
  always_comb begin
    // NOTE: default first so no path through the case leaves adv unassigned (no latch).
    adv = 1'b0;
    case (state)
      S_IF:       adv = mem_ready;
      S_DE, S_EX: adv = 1'b1;
      S_WB:       adv = (wb_kind == WB_NONE) ? 1'b1 : mem_ready;
      default:    adv = 1'b0;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wb_kind     <= WB_NONE;
      single_step <= 1'b0;
      cstate      <= PH_NONE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= ERR_NONE;
      instret     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run || step) begin
            state       <= S_IF;
            single_step <= !run;
            cstate      <= PH_IF;
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            busy        <= 1'b1;
          end
        end

        S_IF: begin
          if (mem_ready) begin
            state   <= S_DE;
            cstate  <= PH_DE;
            mem_req <= 1'b0;
          end else if (expired) begin
            state   <= S_HALT;
            cstate  <= PH_NONE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b1;
            err     <= ERR_TIMEOUT;
          end
        end

        S_DE: begin
          if (!opcode_legal(opcode) || opcode == OP_SYSTEM) begin
            // ECALL/EBREAK retire and stop cleanly; anything unknown stops
            // without retiring and records the error.
            state  <= S_HALT;
            cstate <= PH_NONE;
            busy   <= 1'b0;
            halted <= 1'b1;
            if (opcode == OP_SYSTEM) instret <= instret + CNT_W'(1);
            else                     err     <= ERR_ILLEGAL;
          end else begin
            state   <= S_EX;
            cstate  <= PH_EX;
            wb_kind <= wb_kind_of(opcode);
          end
        end

        S_EX: begin
          state   <= S_WB;
          cstate  <= PH_WB;
          mem_req <= (wb_kind != WB_NONE);
          mem_we  <= (wb_kind == WB_STORE);
        end

        S_WB: begin
          if (wb_kind == WB_NONE || mem_ready) begin
            instret     <= instret + CNT_W'(1);
            single_step <= 1'b0;
            mem_we      <= 1'b0;
            if (run && !single_step) begin
              state   <= S_IF;
              cstate  <= PH_IF;
              mem_req <= 1'b1;
            end else begin
              state   <= S_IDLE;
              cstate  <= PH_NONE;
              mem_req <= 1'b0;
              busy    <= 1'b0;
            end
          end else if (expired) begin
            state   <= S_HALT;
            cstate  <= PH_NONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b1;
            err     <= ERR_TIMEOUT;
          end
        end

        default: begin
          // HALT is left only through reset.
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed self-checking bench for seq_controller.
module tb_seq_controller;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  localparam logic [31:0] I_ADDI  = 32'h0010_0093;
  localparam logic [31:0] I_LW    = 32'h0000_2083;
  localparam logic [31:0] I_SW    = 32'h0011_2023;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;
  localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             step;
  logic [31:0]      ir;
  logic             mem_ready;
  logic [3:0]       cstate;
  logic             adv;
  logic             mem_req;
  logic             mem_we;
  logic             busy;
  logic             halted;
  logic [1:0]       err;
  logic [CNT_W-1:0] instret;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .ir        (ir),
    .mem_ready (mem_ready),
    .cstate    (cstate),
    .adv       (adv),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".cstate"},  32'(cstate),  32'h0);
    check({tag, ".adv"},     32'(adv),     32'h0);
    check({tag, ".mem_req"}, 32'(mem_req), 32'h0);
    check({tag, ".mem_we"},  32'(mem_we),  32'h0);
    check({tag, ".busy"},    32'(busy),    32'h0);
    check({tag, ".halted"},  32'(halted),  32'h0);
    check({tag, ".err"},     32'(err),     32'h0);
    check({tag, ".instret"}, 32'(instret), 32'h0);
  endtask

  logic [3:0] phase_seq [4];
  int         req_cycles;

  initial begin
    phase_seq[0] = 4'b0001;
    phase_seq[1] = 4'b0010;
    phase_seq[2] = 4'b0100;
    phase_seq[3] = 4'b1000;

    // Reset state.
    rst_n = 1'b0; run = 1'b0; step = 1'b0; mem_ready = 1'b0; ir = I_ADDI;
    #12;
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();
    check("idle_no_run.cstate", 32'(cstate), 32'h0);
    check("idle_no_run.busy",   32'(busy),   32'h0);

    // Continuous ADDI with memory always ready.
    run = 1'b1; mem_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("addi[%0d].cstate", i), 32'(cstate), 32'(phase_seq[i % 4]));
      check($sformatf("addi[%0d].adv", i), 32'(adv), 32'h1);
      check($sformatf("addi[%0d].instret", i), 32'(instret), 32'(i / 4));
      if (i == 3) check("addi_wb.mem_req", 32'(mem_req), 32'h0);
      tick();
    end
    check("addi_end.instret", 32'(instret), 32'h2);
    check("addi_end.cstate",  32'(cstate),  32'h1);

    // LW with three wait cycles in WB; run drops before it retires.
    ir = I_LW;
    tick();  // DE
    tick();  // EX
    mem_ready = 1'b0;
    tick();  // WB
    for (int w = 0; w < 3; w++) begin
      check($sformatf("lw_wait[%0d].cstate", w), 32'(cstate), 32'h8);
      check($sformatf("lw_wait[%0d].mem_req", w), 32'(mem_req), 32'h1);
      check($sformatf("lw_wait[%0d].mem_we", w), 32'(mem_we), 32'h0);
      check($sformatf("lw_wait[%0d].adv", w), 32'(adv), 32'h0);
      tick();
    end
    mem_ready = 1'b1; run = 1'b0;
    #1;
    check("lw_done.adv",     32'(adv),     32'h1);
    check("lw_done.mem_req", 32'(mem_req), 32'h1);
    check("lw_done.instret", 32'(instret), 32'h2);
    tick();
    check("lw_retired.instret", 32'(instret), 32'h3);
    check("lw_retired.cstate",  32'(cstate),  32'h0);
    check("lw_retired.busy",    32'(busy),    32'h0);
    check("lw_retired.adv",     32'(adv),     32'h0);

    // Single step.
    ir = I_ADDI; step = 1'b1;
    tick();
    step = 1'b0;
    check("step_if.cstate", 32'(cstate), 32'h1);
    check("step_if.busy",   32'(busy),   32'h1);
    repeat (4) tick();
    check("step_done.instret", 32'(instret), 32'h4);
    check("step_done.cstate",  32'(cstate),  32'h0);
    check("step_done.busy",    32'(busy),    32'h0);
    tick();
    check("step_stays_idle.instret", 32'(instret), 32'h4);
    check("step_stays_idle.cstate",  32'(cstate),  32'h0);

    // Illegal opcode halts after DE without retiring.
    ir = I_BAD; run = 1'b1;
    tick();  // IF
    tick();  // DE
    check("illegal_de.cstate", 32'(cstate), 32'h2);
    check("illegal_de.adv",    32'(adv),    32'h1);
    tick();
    check("illegal.halted",  32'(halted),  32'h1);
    check("illegal.err",     32'(err),     32'h1);
    check("illegal.instret", 32'(instret), 32'h4);
    check("illegal.busy",    32'(busy),    32'h0);
    check("illegal.cstate",  32'(cstate),  32'h0);
    check("illegal.adv",     32'(adv),     32'h0);
    step = 1'b1;
    repeat (2) tick();
    check("halt_sticky.halted", 32'(halted), 32'h1);
    check("halt_sticky.cstate", 32'(cstate), 32'h0);
    check("halt_sticky.err",    32'(err),    32'h1);
    step = 1'b0;

    // Reset out of HALT, then fetch timeout.
    ir = I_ADDI; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_from_halt");
    rst_n = 1'b1;
    tick();  // IF
    req_cycles = 0;
    while (mem_req && req_cycles < 40) begin
      req_cycles++;
      check($sformatf("timeout_wait[%0d].adv", req_cycles), 32'(adv), 32'h0);
      tick();
    end
    check("timeout.req_cycles", 32'(req_cycles), 32'd16);
    check("timeout.halted",     32'(halted),     32'h1);
    check("timeout.err",        32'(err),        32'h2);
    check("timeout.mem_req",    32'(mem_req),    32'h0);
    check("timeout.instret",    32'(instret),    32'h0);

    // Reset, retire one ADDI by stepping.
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    mem_ready = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    repeat (4) tick();
    check("step2.instret", 32'(instret), 32'h1);

    // Store: memory answers exactly on the timeout cycle of IF, which completes.
    ir = I_SW; run = 1'b1; mem_ready = 1'b0;
    tick();  // IF, wait count 0
    repeat (15) tick();
    mem_ready = 1'b1;
    #1;
    check("boundary.adv", 32'(adv), 32'h1);
    tick();
    check("boundary.cstate", 32'(cstate), 32'h2);
    check("boundary.halted", 32'(halted), 32'h0);
    mem_ready = 1'b0;
    tick();  // EX
    tick();  // WB
    check("sw_wb.mem_req", 32'(mem_req), 32'h1);
    check("sw_wb.mem_we",  32'(mem_we),  32'h1);
    check("sw_wb.adv",     32'(adv),     32'h0);
    tick();
    check("sw_wb2.mem_req", 32'(mem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_mid_store");
    rst_n = 1'b1;

    // ECALL retires and halts without error.
    ir = I_ECALL; mem_ready = 1'b1;
    tick();  // IF
    tick();  // DE
    tick();
    check("ecall.halted",  32'(halted),  32'h1);
    check("ecall.err",     32'(err),     32'h0);
    check("ecall.instret", 32'(instret), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum memory wait cycles per access; legal range 2..256.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-005 run  input  1  level; high permits continuous execution.
REQ-006 step  input  1  level; sampled only in IDLE; executes exactly one instruction.
REQ-007 ir  input  32  current instruction register contents.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 cstate  output  4  one-hot phase: IF=0001, DE=0010, EX=0100, WB=1000; 0000 in IDLE/HALT.
REQ-010 adv  output  1  current phase completes this cycle; downstream load strobes qualify on it.
REQ-011 mem_req  output  1  memory access request.
REQ-012 mem_we  output  1  request is a write; valid only with mem_req.
REQ-013 busy  output  1  high in every state except IDLE and HALT.
REQ-014 halted  output  1  high in HALT.
REQ-015 err  output  2  00 none, 01 illegal opcode, 10 memory timeout; sticky until reset.
REQ-016 instret  output  CNT_W  count of retired instructions.

Function
REQ-017 States SHALL be IDLE, IF, DE, EX, WB, HALT; state register one-hot or binary at implementer's choice, cstate decoded per REQ-009.
REQ-018 IDLE->IF when run=1 or step=1; step=1 with run=0 SHALL set an internal single-step flag.
REQ-019 IF SHALL assert mem_req=1, mem_we=0 and hold until mem_ready=1; adv=1 on the mem_ready cycle; next state DE.
REQ-020 DE SHALL last one cycle with adv=1; ir[6:0] SHALL be checked against {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011}.
REQ-021 DE with opcode not in set -> HALT, err=01, instret unchanged.
REQ-022 DE with opcode 1110011 (ECALL/EBREAK) -> HALT, err=00, instret incremented.
REQ-023 EX SHALL last one cycle with adv=1; next state WB.
REQ-024 WB for opcode 0000011 SHALL assert mem_req=1, mem_we=0; for 0100011 mem_req=1, mem_we=1; both held until mem_ready=1, adv=1 on that cycle.
REQ-025 WB for all other opcodes SHALL last one cycle, mem_req=0, adv=1.
REQ-026 WB completion SHALL increment instret by 1 (wrapping modulo 2^CNT_W), then go IF if run=1 and single-step flag clear, else IDLE, clearing the single-step flag.
REQ-027 A wait counter SHALL clear on entry to each memory access and increment each cycle mem_ready=0; reaching TIMEOUT-1 with mem_ready=0 -> HALT, err=10, mem_req dropped next cycle.
REQ-028 mem_ready=1 on the first request cycle SHALL give zero wait cycles (IF then lasts exactly one cycle).
REQ-029 mem_ready while mem_req=0 SHALL be ignored.
REQ-030 run falling mid-instruction SHALL not abort it; the instruction retires and the block enters IDLE.
REQ-031 HALT SHALL be exited only by reset; run/step ignored.
REQ-032 Simultaneous mem_ready=1 and timeout threshold in the same cycle SHALL count as completion, not timeout.
REQ-033 adv SHALL be 0 in IDLE and HALT and in every wait cycle.

Reset
REQ-034 On reset low: state IDLE, cstate=0000, adv=0, mem_req=0, mem_we=0, busy=0, halted=0, err=00, instret=0, wait counter=0, single-step flag=0.
REQ-035 Reset asserted mid-access SHALL drop mem_req asynchronously; no completion is recorded.

Structure
REQ-036 Phase encodings, opcode constants and err codes SHALL live in the shared kappa package.
REQ-037 The wait/timeout counter SHALL be one sub-module, mem_wait_timer, parametrised by TIMEOUT.
REQ-038 Decoding of datapath selects remains in the existing combinational controller, which consumes cstate and adv.

Verification
REQ-039 run=1, ir=ADDI (0x00100093), mem_ready tied 1 -> cstate 0001,0010,0100,1000 repeating, instret=1 after 4 cycles, 2 after 8.
REQ-040 LW (0x00002083), mem_ready low 3 cycles in WB -> WB lasts 4 cycles, mem_req=1 throughout, adv=1 only on 4th.
REQ-041 IF with mem_ready never high, TIMEOUT=16 -> HALT after 16 request cycles, err=10, halted=1, mem_req=0.
REQ-042 ir=0xFFFFFFFF -> HALT after DE, err=01, instret unchanged.
REQ-043 run=0, step pulsed one cycle -> exactly one instruction retires, back to IDLE, busy=0.
REQ-044 reset low during store WB wait -> all outputs at REQ-034 values same cycle, instret=0.
